// File: rtl/alu2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu2_pkg
// Description : Shared opcodes, FSM encoding and width for the alu2 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu2_pkg;

    localparam int WIDTH = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADD1 = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : alu2_pkg
`default_nettype wire

// File: rtl/alu2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu2_arbiter_if
// Description : Two-requester operation bus between sources and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu2_arbiter_if #(
    parameter int WIDTH = alu2_pkg::WIDTH
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       c0;
    logic [1:0]       c1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, c0, c1,
        input  done0, done1, result, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, c0, c1,
        output done0, done1, result, busy
    );

endinterface : alu2_arbiter_if
`default_nettype wire

// File: rtl/alu2_altonivel.sv
`default_nettype none
// ============================================================================
// Module      : alu2_altonivel
// Description : Combinational 2-bit-opcode ALU (add, add+1, and, xor), mod 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
module alu2_altonivel #(
    parameter int WIDTH = alu2_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_c,
    output logic [WIDTH-1:0] o_f
);
    import alu2_pkg::*;

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Carry-out is dropped; A+B+1 is one truncated sum.
    always_comb begin
        o_f = '0;
        case (i_c)
            OP_ADD:  o_f = i_a + i_b;
            OP_ADD1: o_f = i_a + i_b + c_ONE;
            OP_AND:  o_f = i_a & i_b;
            OP_XOR:  o_f = i_a ^ i_b;
            default: o_f = '0;
        endcase
    end

endmodule : alu2_altonivel
`default_nettype wire

// File: rtl/alu2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu2_arbiter
// Description : Round-robin share of one alu2_altonivel between two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu2_arbiter #(
    parameter int WIDTH = alu2_pkg::WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    alu2_arbiter_if.slave bus
);
    import alu2_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic [1:0]       r_c_q;
    logic [WIDTH-1:0] r_result_q;
    logic             r_owner;
    logic             r_last;
    logic             w_grant;
    logic             w_winner;
    logic [WIDTH-1:0] w_alu_f;

    // On a tie the requester not served last wins.
    always_comb begin
        w_grant  = bus.req0 | bus.req1;
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_winner = ~r_last;
        end else if (bus.req1) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_c_q      <= '0;
            r_result_q <= '0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
        end else begin
            if (r_state == IDLE && w_grant) begin
                r_owner <= w_winner;
                r_a_q   <= w_winner ? bus.a1 : bus.a0;
                r_b_q   <= w_winner ? bus.b1 : bus.b0;
                r_c_q   <= w_winner ? bus.c1 : bus.c0;
            end
            if (r_state == EXEC) begin
                r_result_q <= w_alu_f;
            end
            if (r_state == RESP) begin
                r_last <= r_owner;
            end
        end
    end

    alu2_altonivel #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a (r_a_q),
        .i_b (r_b_q),
        .i_c (r_c_q),
        .o_f (w_alu_f)
    );

    assign bus.done0  = (r_state == RESP) && !r_owner;
    assign bus.done1  = (r_state == RESP) &&  r_owner;
    assign bus.busy   = (r_state != IDLE);
    assign bus.result = r_result_q;

endmodule : alu2_arbiter
`default_nettype wire

// File: tb/tb_alu2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu2_arbiter
// Description : Scoreboard bench for alu2_arbiter (ordering, results, latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu2_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu2_arbiter_if #(.WIDTH(4)) bus ();

    alu2_arbiter #(.WIDTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       owner;
        logic [3:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] c);
        int s;
        case (c)
            2'b00:   s = (int'(a) + int'(b)) % 16;
            2'b01:   s = (int'(a) + int'(b) + 1) % 16;
            2'b10:   s = int'(a & b);
            default: s = int'(a ^ b);
        endcase
        return s[3:0];
    endfunction

    task automatic push(input logic who, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] c);
        exp_t e;
        e.owner = who;
        e.res   = ref_alu(a, b, c);
        sb.push_back(e);
    endtask

    task automatic drive(input logic who, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] c);
        if (who) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.c1 = c;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.c0 = c;
        end
    endtask

    task automatic drop(input logic who);
        if (who) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
    endtask

    // Counts negedges until a done appears; expiry is a failed comparison.
    task automatic wait_done(output int n, output logic who);
        n   = 0;
        who = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (bus.done0 || bus.done1) begin
                who = bus.done1;
                return;
            end
        end
        check("wait_done_timeout", {31'd0, bus.done0 | bus.done1}, 32'd1);
    endtask

    task automatic single_op(input logic who, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] c, input string tag);
        @(posedge clk); #1;
        drive(who, a, b, c);
        push(who, a, b, c);
        @(negedge clk); check({tag, "_idle_busy"}, bus.busy, 0);
        @(negedge clk); check({tag, "_exec_busy"}, bus.busy, 1);
        @(negedge clk); check({tag, "_resp_done"}, who ? bus.done1 : bus.done0, 1);
        @(posedge clk); #1;
        drop(who);
        @(negedge clk); check({tag, "_back_idle"}, bus.busy, 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.done0 || bus.done1) begin
            check("done_onehot", {31'd0, bus.done0 & bus.done1}, 0);
            if (sb.size() == 0) begin
                check("sb_unexpected_done", {31'd0, bus.done1}, {31'd0, ~bus.done1});
            end else begin
                e = sb.pop_front();
                check("sb_owner", {31'd0, bus.done1}, {31'd0, e.owner});
                check("sb_result", {28'd0, bus.result}, {28'd0, e.res});
            end
        end
    end

    initial begin
        int   n;
        logic who;

        rst = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 4'h2; bus.b0 = 4'h3; bus.c0 = 2'b00;
        bus.req1 = 1'b1; bus.a1 = 4'h9; bus.b1 = 4'h5; bus.c1 = 2'b11;
        repeat (2) begin
            @(negedge clk);
            check("rst_done0", bus.done0, 0);
            check("rst_done1", bus.done1, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_result", bus.result, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push(1'b0, 4'h2, 4'h3, 2'b00);
        push(1'b1, 4'h9, 4'h5, 2'b11);
        wait_done(n, who);
        check("first_lat", n, 3);
        check("first_who", {31'd0, who}, 0);
        @(posedge clk); #1;
        drop(1'b0);
        wait_done(n, who);
        check("loser_lat", n, 3);
        @(posedge clk); #1;
        drop(1'b1);

        single_op(1'b0, 4'h7, 4'h5, 2'b00, "single");
        single_op(1'b1, 4'hF, 4'hF, 2'b01, "add1_wrap");
        single_op(1'b1, 4'hF, 4'h1, 2'b00, "add_wrap");
        single_op(1'b1, 4'hC, 4'hA, 2'b10, "and");
        single_op(1'b1, 4'hC, 4'hA, 2'b11, "xor");

        // Continuous contention: strict alternation, one done per 3 cycles.
        @(posedge clk); #1;
        drive(1'b0, 4'h3, 4'h4, 2'b00);
        drive(1'b1, 4'h3, 4'h6, 2'b10);
        for (int i = 0; i < 4; i++) begin
            push(i[0], i[0] ? 4'h3 : 4'h3, i[0] ? 4'h6 : 4'h4, i[0] ? 2'b10 : 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            wait_done(n, who);
            check("cont_lat", n, 3);
            check("cont_who", {31'd0, who}, i % 2);
        end
        @(posedge clk); #1;
        drop(1'b0);
        drop(1'b1);

        // Operands changed after the grant must not leak in.
        @(posedge clk); #1;
        drive(1'b0, 4'h1, 4'h1, 2'b00);
        push(1'b0, 4'h1, 4'h1, 2'b00);
        @(posedge clk); #1;
        bus.a0 = 4'hE;
        wait_done(n, who);
        check("capture_lat", n, 2);
        @(posedge clk); #1;
        drop(1'b0);

        // Reset during EXEC: op dropped, last restored so the tie goes to 0.
        @(posedge clk); #1;
        drive(1'b1, 4'h5, 4'h5, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        drop(1'b1);
        @(negedge clk); check("midrst_exec_busy", bus.busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_result", bus.result, 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, bus.done0 | bus.done1}, 0);
        end
        @(posedge clk); #1;
        drive(1'b0, 4'h8, 4'h8, 2'b00);
        drive(1'b1, 4'h1, 4'h2, 2'b00);
        push(1'b0, 4'h8, 4'h8, 2'b00);
        push(1'b1, 4'h1, 4'h2, 2'b00);
        wait_done(n, who);
        check("tie_after_rst_who", {31'd0, who}, 0);
        @(posedge clk); #1;
        drop(1'b0);
        wait_done(n, who);
        check("tie_loser_who", {31'd0, who}, 1);
        @(posedge clk); #1;
        drop(1'b1);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu2_arbiter
`default_nettype wire

// File: doc/alu2_arbiter.md
# alu2_arbiter

Shares one 4-bit `alu2_altonivel` datapath between two independent requesters. It uses a round-robin arbiter and a three-state sequencer. Each requester presents operands and a 2-bit opcode and holds `req` high. The block latches the winning request, evaluates it on the shared ALU, and returns a registered result with a one-cycle `done` pulse to that requester only. It sits between the two operation sources and the single ALU instance.

## Interface
- `WIDTH`, default 4: datapath width. Fixed at 4 to match `alu2_altonivel`; other values are unsupported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  operation request from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1`  in  4  operands of requester 0 / 1.
- `c0`, `c1`  in  2  opcode of requester 0 / 1:
  - 00 = A+B
  - 01 = A+B+1
  - 10 = A&B
  - 11 = A^B
- `done0`, `done1`  out  1  one-cycle completion pulse to requester 0 / 1.
- `result`  out  4  result of the completed op; valid only while a `done` is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no `req` is high, stay in IDLE.
  - If exactly one `req` is high, grant it.
  - If both are high, grant the requester not served last (`last` register). After reset, `last` = 1, so requester 0 wins the first tie.
  - On grant, latch `a`, `b`, `c` of the winner into `a_q`, `b_q`, `c_q`, set `owner`, and go to EXEC.
- EXEC: `result_q <= F` of `alu2_altonivel(a_q, b_q, c_q)`. Go to RESP.
- RESP:
  - `done[owner]` = 1. The other `done` = 0.
  - `result` = `result_q`.
  - `last <= owner`.
  - Go to IDLE.
- Outputs are decoded from registers only, with no combinational path from inputs to outputs.
  - `done0` = (state==RESP && owner==0).
  - `done1` = (state==RESP && owner==1).
  - `busy` = (state!=IDLE).
  - `result` = `result_q`, held until the next EXEC overwrites it.
- Arithmetic is modulo 16. The carry-out is discarded. A+B+1 is computed as a single 4-bit sum, e.g. F+F+1 = F.
- Operand capture: inputs are sampled only at the grant edge. Changes after the grant do not affect the in-flight op.
- Requester contract: hold `req` and operands stable until the corresponding `done` is seen.
  - If `req` is still high in the cycle after `done`, it is a new request and competes normally in IDLE.
- Fairness:
  - With both requesters continuously requesting, grants strictly alternate.
  - No requester waits more than one foreign operation (at most 3 extra cycles).
- Reset (`rst`=1 at any edge, including mid-EXEC/RESP):
  - State → IDLE.
  - `a_q`/`b_q`/`c_q`/`result_q` → 0.
  - `owner` → 0, `last` → 1.
  - The in-flight op is dropped and no `done` is issued for it.
  - `rst` overrides all other inputs.

## Timing
- Reset values: `done0`=0, `done1`=0, `result`=0, `busy`=0.
- Single op, `req` high during cycle N with FSM in IDLE:
  - Granted at the end of N.
  - EXEC in N+1 (`busy`=1).
  - RESP in N+2: `done` and `result` valid.
  - IDLE in N+3.
  - Latency from grant edge to `done` is 2 cycles.
- Maximum throughput is one op per 3 cycles.
- A back-to-back request held high through `done` is granted at the end of N+3. Its `done` arrives in N+5.
- A `req` raised while `busy`=1 is ignored until IDLE. It is then arbitrated against whatever is pending.
- Simultaneous `req0` and `req1` in IDLE: exactly one is granted. The loser keeps `req` high and is granted at the next IDLE.

## Structure
- Shared package `alu2_pkg`:
  - Opcode constants OP_ADD=2'b00, OP_ADD1=2'b01, OP_AND=2'b10, OP_XOR=2'b11.
  - FSM state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - WIDTH=4.
- The one natural sub-module is the existing `alu2_altonivel`, instantiated once and driven only from `a_q`/`b_q`/`c_q`.
- Keep the arbiter (winner select plus `last` update) inside this module; it is too small to split out.

## Test plan
- Reset: hold `rst` 2 cycles with both `req` high → `done0`=`done1`=0, `busy`=0, `result`=0. After release, requester 0 is granted first.
- Single op: `req0`=1, a0=4'h7, b0=4'h5, c0=00 → `done0` pulses 2 cycles after the grant with `result`=4'hC; `done1` stays 0.
- All opcodes with wrap, on requester 1:
  - a1=F, b1=F, c1=01 → F.
  - a1=F, b1=1, c1=00 → 0.
  - a1=C, b1=A, c1=10 → 8.
  - a1=C, b1=A, c1=11 → 6.
- Contention: both `req` held high for 12 cycles, requester 0 doing 3+4 and requester 1 doing 3&6 → `done` order 0,1,0,1 with results 7,2,7,2, one `done` every 3 cycles.
- Operand capture: change a0 from 4'h1 to 4'hE the cycle after the grant (b0=1, c0=00) → `result`=2.
- Reset mid-op: assert `rst` during EXEC → no `done` follows, `busy`=0 next cycle, `last`=1, and a subsequent tie goes to requester 0.
